// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes and the ID->EX
// control bundle carried alongside the operands.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 16;

  localparam logic [OP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [OP_W-1:0] ALU_AND = 4'h2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [OP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [OP_W-1:0] ALU_SLL = 4'h5;
  localparam logic [OP_W-1:0] ALU_SRL = 4'h6;
  localparam logic [OP_W-1:0] ALU_SLT = 4'h7;

  // Control bits that travel from ID to EX with each instruction.
  typedef struct packed {
    logic            wb;
    logic            mem_read;
    logic            mem_write;
    logic [OP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: an instruction in ID that reads the register
// a load in EX is about to write must wait one cycle for the load data.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_W = cpu_pkg::REG_W
) (
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_wb_i,
  input  logic [REG_W-1:0] ex_rdst_i,
  input  logic             id_valid_i,
  input  logic             id_use1_i,
  input  logic [REG_W-1:0] id_rsrc1_i,
  input  logic             id_use2_i,
  input  logic [REG_W-1:0] id_rsrc2_i,
  input  logic             flush_i,
  output logic             lu_o,
  output logic             stall_fd_o
);

  logic hit1, hit2;

  // Register 0 is an ordinary register here, so a match on it stalls too.
  always_comb begin
    hit1       = id_use1_i && (id_rsrc1_i == ex_rdst_i);
    hit2       = id_use2_i && (id_rsrc2_i == ex_rdst_i);
    lu_o       = ex_valid_i && ex_mem_read_i && ex_wb_i && id_valid_i && (hit1 || hit2);
    stall_fd_o = lu_o && !flush_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// global freeze and a saturating count of inserted load-use bubbles.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W,
  parameter int OP_W   = cpu_pkg::OP_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rsrc1,
  input  logic [REG_W-1:0]  id_rsrc2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_W-1:0]  id_rdst,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_wb,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              flush,
  input  logic              freeze,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rsrc1,
  output logic [REG_W-1:0]  ex_rsrc2,
  output logic              ex_use1,
  output logic              ex_use2,
  output logic [REG_W-1:0]  ex_rdst,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_wb,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic              stall_fd,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rsrc1;
    logic [REG_W-1:0]  rsrc2;
    logic              use1;
    logic              use2;
    logic [REG_W-1:0]  rdst;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic              wb;
    logic              mem_read;
    logic              mem_write;
    logic [OP_W-1:0]   alu_op;
  } ex_t;

  ex_t              id_bus, ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             lu;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign id_bus = {id_valid, id_rsrc1, id_rsrc2, id_use1, id_use2, id_rdst,
                   id_rd1, id_rd2, id_imm, id_wb, id_mem_read, id_mem_write,
                   id_alu_op};

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_valid_i    (ex_q.valid),
    .ex_mem_read_i (ex_q.mem_read),
    .ex_wb_i       (ex_q.wb),
    .ex_rdst_i     (ex_q.rdst),
    .id_valid_i    (id_valid),
    .id_use1_i     (id_use1),
    .id_rsrc1_i    (id_rsrc1),
    .id_use2_i     (id_use2),
    .id_rsrc2_i    (id_rsrc2),
    .flush_i       (flush),
    .lu_o          (lu),
    .stall_fd_o    (stall_fd)
  );

  // Next-state selection: flush beats freeze beats load-use beats normal advance.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (freeze) begin
      ex_d = ex_q;
    end else if (lu) begin
      ex_d  = '0;
      cnt_d = sat_inc(cnt_q);
    end else begin
      ex_d = id_bus;
    end
  end

  // Pipeline register and bubble counter, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_rsrc1     = ex_q.rsrc1;
  assign ex_rsrc2     = ex_q.rsrc2;
  assign ex_use1      = ex_q.use1;
  assign ex_use2      = ex_q.use2;
  assign ex_rdst      = ex_q.rdst;
  assign ex_rd1       = ex_q.rd1;
  assign ex_rd2       = ex_q.rd2;
  assign ex_imm       = ex_q.imm;
  assign ex_wb        = ex_q.wb;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_alu_op    = ex_q.alu_op;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_id_ex_stage;

  localparam int CW = 4;  // narrow counter so saturation is reachable quickly

  typedef struct packed {
    logic        valid;
    logic [2:0]  rsrc1;
    logic [2:0]  rsrc2;
    logic        use1;
    logic        use2;
    logic [2:0]  rdst;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  op;
  } fld_t;

  logic clk, rst_n, flush, freeze;
  logic id_valid, id_use1, id_use2, id_wb, id_mem_read, id_mem_write;
  logic [2:0] id_rsrc1, id_rsrc2, id_rdst;
  logic [15:0] id_rd1, id_rd2, id_imm;
  logic [3:0] id_alu_op;
  logic ex_valid, ex_use1, ex_use2, ex_wb, ex_mem_read, ex_mem_write;
  logic [2:0] ex_rsrc1, ex_rsrc2, ex_rdst;
  logic [15:0] ex_rd1, ex_rd2, ex_imm;
  logic [3:0] ex_alu_op;
  logic stall_fd;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 0;

  fld_t cur_id, dut_ex, m_ex;
  logic [CW-1:0] m_cnt;

  id_ex_stage #(.DATA_W(16), .REG_W(3), .OP_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rsrc1(id_rsrc1),
    .id_rsrc2(id_rsrc2), .id_use1(id_use1), .id_use2(id_use2), .id_rdst(id_rdst),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_wb(id_wb),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
    .flush(flush), .freeze(freeze), .ex_valid(ex_valid), .ex_rsrc1(ex_rsrc1),
    .ex_rsrc2(ex_rsrc2), .ex_use1(ex_use1), .ex_use2(ex_use2), .ex_rdst(ex_rdst),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_wb(ex_wb),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
    .stall_fd(stall_fd), .stall_cnt(stall_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  assign cur_id = {id_valid, id_rsrc1, id_rsrc2, id_use1, id_use2, id_rdst, id_rd1,
                   id_rd2, id_imm, id_wb, id_mem_read, id_mem_write, id_alu_op};
  assign dut_ex = {ex_valid, ex_rsrc1, ex_rsrc2, ex_use1, ex_use2, ex_rdst, ex_rd1,
                   ex_rd2, ex_imm, ex_wb, ex_mem_read, ex_mem_write, ex_alu_op};

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Does the ID instruction need a register the load in EX has not produced yet?
  function automatic logic model_lu();
    logic reads_it;
    reads_it = (cur_id.use1 && cur_id.rsrc1 == m_ex.rdst) ||
               (cur_id.use2 && cur_id.rsrc2 == m_ex.rdst);
    return m_ex.valid && m_ex.mr && m_ex.wb && cur_id.valid && reads_it;
  endfunction

  // Reference: what EX must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex = '0;
      m_cnt = '0;
    end else if (flush) begin
      m_ex = '0;
    end else if (freeze) begin
      m_ex = m_ex;
    end else if (model_lu()) begin
      m_ex = '0;
      if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else begin
      m_ex = cur_id;
    end
  end

  // Continuous comparison on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ex_bundle", dut_ex, m_ex);
      chk("stall_fd", stall_fd, rst_n && model_lu() && !flush);
      chk("stall_cnt", stall_cnt, m_cnt);
    end
  end

  task automatic drive(input fld_t v);
    {id_valid, id_rsrc1, id_rsrc2, id_use1, id_use2, id_rdst, id_rd1, id_rd2, id_imm,
     id_wb, id_mem_read, id_mem_write, id_alu_op} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic fld_t rand_id();
    fld_t v;
    v = {$urandom, $urandom, $urandom};
    v.rsrc1 = 3'($urandom_range(0, 3));
    v.rsrc2 = 3'($urandom_range(0, 3));
    v.rdst  = 3'($urandom_range(0, 3));
    v.mr    = ($urandom_range(0, 9) < 4);
    v.wb    = ($urandom_range(0, 9) < 7);
    v.valid = ($urandom_range(0, 9) < 8);
    return v;
  endfunction

  function automatic fld_t mk_load(input logic [2:0] rd, input logic mr, input logic wb);
    fld_t v;
    v = '0;
    v.valid = 1; v.rdst = rd; v.mr = mr; v.wb = wb; v.rd1 = 16'h0101;
    return v;
  endfunction

  function automatic fld_t mk_use(input logic u1, input logic [2:0] r1,
                                  input logic u2, input logic [2:0] r2);
    fld_t v;
    v = '0;
    v.valid = 1; v.use1 = u1; v.rsrc1 = r1; v.use2 = u2; v.rsrc2 = r2;
    v.rdst = 3'd4; v.wb = 1; v.op = 4'h1;
    return v;
  endfunction

  // Put a producer into EX and present a consumer in ID.
  task automatic load_then(input fld_t ld, input fld_t cons);
    drive(ld);
    step();
    drive(cons);
    #1;
  endtask

  initial begin
    fld_t v;
    rst_n = 0; flush = 0; freeze = 0;
    drive('0);
    repeat (2) step();
    rst_n = 1;
    cmp_en = 1;

    // Reset asserted mid-cycle with garbage on ID.
    drive(mk_load(3'd5, 1, 1));
    step();
    drive(mk_use(1, 3'd5, 0, 3'd0));
    #2;
    drive({$urandom, $urandom, $urandom} | 67'h1);
    rst_n = 0;
    #1;
    chk("reset_ex", dut_ex, '0);
    chk("reset_cnt", stall_cnt, '0);
    chk("reset_stall_fd", stall_fd, 1'b0);
    step();
    rst_n = 1;

    // Pass-through.
    v = '0;
    v.valid = 1; v.rsrc1 = 3'd0; v.rsrc2 = 3'd1; v.rdst = 3'd2; v.rd1 = 16'h1234;
    v.imm = 16'hFFFE; v.wb = 1; v.use1 = 1; v.use2 = 1; v.op = 4'h3;
    drive(v);
    step();
    chk("pass_valid", ex_valid, 1'b1);
    chk("pass_rsrc", {ex_rsrc1, ex_rsrc2, ex_rdst}, {3'd0, 3'd1, 3'd2});
    chk("pass_rd1", ex_rd1, 16'h1234);
    chk("pass_imm", ex_imm, 16'hFFFE);
    chk("pass_wb_op", {ex_wb, ex_mem_read, ex_alu_op}, {1'b1, 1'b0, 4'h3});

    // Load-use on rsrc2.
    load_then(mk_load(3'd3, 1, 1), mk_use(0, 3'd5, 1, 3'd3));
    chk("lu_stall_fd", stall_fd, 1'b1);
    step();
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_cnt", stall_cnt, 4'd1);
    chk("lu_released", stall_fd, 1'b0);
    step();
    chk("lu_consumer", {ex_valid, ex_rsrc2, ex_rdst}, {1'b1, 3'd3, 3'd4});

    // No false stalls.
    load_then(mk_load(3'd3, 1, 1), mk_use(0, 3'd5, 0, 3'd3));
    chk("nouse_fd", stall_fd, 1'b0);
    step();
    chk("nouse_adv", ex_valid, 1'b1);
    load_then(mk_load(3'd3, 0, 1), mk_use(0, 3'd5, 1, 3'd3));
    chk("nomr_fd", stall_fd, 1'b0);
    load_then(mk_load(3'd3, 1, 0), mk_use(0, 3'd5, 1, 3'd3));
    chk("nowb_fd", stall_fd, 1'b0);
    v = mk_use(0, 3'd5, 1, 3'd3);
    v.valid = 0;
    load_then(mk_load(3'd3, 1, 1), v);
    chk("idinv_fd", stall_fd, 1'b0);
    step();
    chk("idinv_cnt", stall_cnt, 4'd1);

    // R0 is not special.
    load_then(mk_load(3'd0, 1, 1), mk_use(1, 3'd0, 0, 3'd7));
    chk("r0_fd", stall_fd, 1'b1);
    step();
    chk("r0_cnt", stall_cnt, 4'd2);

    // Flush together with a load-use.
    load_then(mk_load(3'd3, 1, 1), mk_use(0, 3'd5, 1, 3'd3));
    flush = 1;
    #1;
    chk("flush_fd", stall_fd, 1'b0);
    step();
    flush = 0;
    chk("flush_bubble", ex_valid, 1'b0);
    chk("flush_cnt", stall_cnt, 4'd2);

    // Freeze together with a load-use for three cycles.
    load_then(mk_load(3'd3, 1, 1), mk_use(0, 3'd5, 1, 3'd3));
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_fd", stall_fd, 1'b1);
      step();
      chk("frz_hold", {ex_valid, ex_mem_read, ex_rdst}, {1'b1, 1'b1, 3'd3});
    end
    freeze = 0;
    #1;
    chk("frz_rel_fd", stall_fd, 1'b1);
    step();
    chk("frz_bubble", ex_valid, 1'b0);
    chk("frz_cnt", stall_cnt, 4'd3);
    step();
    chk("frz_consumer", {ex_valid, ex_rsrc2}, {1'b1, 3'd3});

    // Saturation.
    for (int i = 0; i < 16; i++) begin
      load_then(mk_load(3'd6, 1, 1), mk_use(1, 3'd6, 0, 3'd0));
      step();
    end
    chk("sat_cnt", stall_cnt, 4'hF);
    load_then(mk_load(3'd6, 1, 1), mk_use(1, 3'd6, 0, 3'd0));
    chk("sat_fd", stall_fd, 1'b1);
    step();
    chk("sat_hold", stall_cnt, 4'hF);

    // Randomized run, including occasional reset mid-stream.
    rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      drive(rand_id());
      flush  = ($urandom_range(0, 9) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      rst_n  = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1; flush = 0; freeze = 0;
    step();

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
